// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared encodings and helpers for the ID-stage branch resolution controller.
// Holds the branch op codes, the FSM state type and the target-PC arithmetic.
package branch_resolve_ctrl_pkg;

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BGTZ = 3'd2;
  localparam logic [2:0] BR_BLTZ = 3'd3;
  localparam logic [2:0] BR_BLEZ = 3'd4;
  localparam logic [2:0] BR_BGEZ = 3'd5;

  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2
  } state_e;

  // Target of a taken branch: the delay-slot PC plus the word-scaled offset.
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                 input logic [15:0] imm);
    return pc + PC_INC + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // Only the two equality compares read rt.
  function automatic logic uses_rt(input logic [2:0] op);
    return (op == BR_BEQ) || (op == BR_BNE);
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_cond_eval.sv
// Combinational branch condition evaluation for the six MIPS branch ops.
// Codes 6 and 7 are flagged illegal and never report taken.
module branch_cond_eval
  import branch_resolve_ctrl_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic        o_taken,
  output logic        o_illegal
);

  logic w_rs_neg;
  logic w_rs_zero;

  assign w_rs_neg  = i_rs[31];
  assign w_rs_zero = (i_rs == 32'd0);

  always_comb begin
    o_taken   = 1'b0;
    o_illegal = 1'b0;
    case (i_op)
      BR_BEQ:  o_taken = (i_rs == i_rt);
      BR_BNE:  o_taken = (i_rs != i_rt);
      BR_BGTZ: o_taken = !w_rs_neg && !w_rs_zero;
      BR_BLTZ: o_taken = w_rs_neg;
      BR_BLEZ: o_taken = w_rs_neg || w_rs_zero;
      BR_BGEZ: o_taken = !w_rs_neg;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch sequencer: holds ID until operands are ready, resolves the
// condition, pulses a redirect with the target PC and keeps branch statistics.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  input  logic [2:0]       br_op,
  input  logic [31:0]      br_pc,
  input  logic [15:0]      br_imm,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic             rs_ready,
  input  logic             rt_ready,
  output logic             stall,
  output logic             br_done,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             err,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int             WCW       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

  state_e           r_state;
  state_e           w_next;
  logic [2:0]       r_op;
  logic [31:0]      r_pc;
  logic [15:0]      r_imm;
  logic [WCW-1:0]   r_wait_cnt;
  logic             r_br_done;
  logic             r_redirect;
  logic             r_err;
  logic [31:0]      r_redirect_pc;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic w_stall;
  logic w_ops_ready;
  logic w_timeout;
  logic w_resolve;
  logic w_taken;
  logic w_illegal;
  logic w_take;

  // The condition is evaluated on the live forwarded operands in the cycle
  // they are accepted, so the registered pulses carry the latched result.
  branch_cond_eval u_cond_eval (
    .i_op      (r_op),
    .i_rs      (rs_data),
    .i_rt      (rt_data),
    .o_taken   (w_taken),
    .o_illegal (w_illegal)
  );

  assign w_ops_ready = rs_ready && (rt_ready || !uses_rt(r_op));
  assign w_timeout   = !w_ops_ready && (r_wait_cnt == WAIT_LAST);
  assign w_resolve   = (r_state == ST_WAIT) && (w_ops_ready || w_timeout);
  assign w_take      = w_taken && !w_illegal && !w_timeout;

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stall = br_valid;
        if (br_valid) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        w_stall = 1'b1;
        if (w_ops_ready || w_timeout) w_next = ST_RESOLVE;
      end
      ST_RESOLVE: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op       <= 3'd0;
      r_pc       <= 32'd0;
      r_imm      <= 16'd0;
      r_wait_cnt <= '0;
    end else if (r_state == ST_IDLE && br_valid) begin
      r_op       <= br_op;
      r_pc       <= br_pc;
      r_imm      <= br_imm;
      r_wait_cnt <= '0;
    end else if (r_state == ST_WAIT && !w_resolve) begin
      r_wait_cnt <= r_wait_cnt + WCW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_br_done     <= 1'b0;
      r_redirect    <= 1'b0;
      r_err         <= 1'b0;
      r_redirect_pc <= 32'd0;
    end else begin
      r_br_done  <= w_resolve;
      r_redirect <= w_resolve && w_take;
      r_err      <= w_resolve && (w_illegal || w_timeout);
      if (w_resolve && w_take) r_redirect_pc <= branch_target(r_pc, r_imm);
    end
  end

  // Counters saturate at all-ones and move on the same edge as the pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
    end else if (w_resolve) begin
      if (r_br_cnt != '1) r_br_cnt <= r_br_cnt + CNT_W'(1);
      if (w_take && r_taken_cnt != '1) r_taken_cnt <= r_taken_cnt + CNT_W'(1);
    end
  end

  assign stall       = w_stall;
  assign br_done     = r_br_done;
  assign redirect    = r_redirect;
  assign err         = r_err;
  assign redirect_pc = r_redirect_pc;
  assign br_cnt      = r_br_cnt;
  assign taken_cnt   = r_taken_cnt;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: a transaction-level model predicts
// each branch's resolve cycle, outcome and counters; checked every cycle.
module tb_branch_resolve_ctrl;

  localparam int WAIT_MAX = 8;
  localparam int CNT_W    = 2;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             br_valid;
  logic [2:0]       br_op;
  logic [31:0]      br_pc;
  logic [15:0]      br_imm;
  logic [31:0]      rs_data;
  logic [31:0]      rt_data;
  logic             rs_ready;
  logic             rt_ready;
  logic             stall;
  logic             br_done;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             err;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;

  branch_resolve_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_op(br_op),
    .br_pc(br_pc), .br_imm(br_imm), .rs_data(rs_data), .rt_data(rt_data),
    .rs_ready(rs_ready), .rt_ready(rt_ready), .stall(stall),
    .br_done(br_done), .redirect(redirect), .redirect_pc(redirect_pc),
    .err(err), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_active = 1'b0;
  int          m_start  = 0;
  int          m_done   = 0;
  bit          m_take   = 1'b0;
  bit          m_err    = 1'b0;
  logic [31:0] m_tgt    = 32'd0;
  logic [31:0] m_last_pc = 32'd0;
  int          m_br     = 0;
  int          m_tk     = 0;
  int          g_start  = 0;

  function automatic bit cond_f(input logic [2:0] op, input logic [31:0] rs,
                                input logic [31:0] rt);
    int signed a;
    a = $signed(rs);
    case (op)
      3'd0:    return rs == rt;
      3'd1:    return rs != rt;
      3'd2:    return a > 0;
      3'd3:    return a < 0;
      3'd4:    return a <= 0;
      3'd5:    return a >= 0;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    bit in_win;
    bit at_done;
    if (!reset) begin
      in_win  = m_active && (cyc >= m_start) && (cyc < m_done);
      at_done = m_active && (cyc == m_done);
      if (at_done) begin
        if (m_br < SAT) m_br++;
        if (m_take) begin
          if (m_tk < SAT) m_tk++;
          m_last_pc = m_tgt;
        end
      end
      chk("stall", {31'd0, stall}, {31'd0, in_win});
      chk("br_done", {31'd0, br_done}, {31'd0, at_done});
      chk("redirect", {31'd0, redirect}, {31'd0, at_done && m_take});
      chk("err", {31'd0, err}, {31'd0, at_done && m_err});
      chk("br_cnt", 32'(br_cnt), 32'(m_br));
      chk("taken_cnt", 32'(taken_cnt), 32'(m_tk));
      chk("redirect_pc", redirect_pc, m_last_pc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_ops(input logic [2:0] op, input logic [31:0] rs,
                           input logic [31:0] rt, input bit rdy);
    if (op == 3'd0 || op == 3'd1) begin
      rs_ready = 1'b1;
      rt_ready = rdy;
    end else begin
      rs_ready = rdy;
      rt_ready = !rdy;
    end
    rs_data = rdy ? rs : ~rs;
    rt_data = rdy ? rt : ~rt;
  endtask

  // Issues one branch; nr = WAIT cycles before the needed operands are ready.
  // Returns just after the edge that raises br_done.
  task automatic issue(input logic [2:0] op, input logic [31:0] pc,
                       input logic [15:0] imm, input logic [31:0] rs,
                       input logic [31:0] rt, input int nr, input bit drop);
    bit tout;
    int s;
    @(posedge clk); #1;
    s       = cyc;
    g_start = s;
    tout    = (nr >= WAIT_MAX);
    m_take  = cond_f(op, rs, rt) && (op <= 3'd5) && !tout;
    m_err   = (op > 3'd5) || tout;
    m_tgt   = pc + 32'(4 + 4 * int'($signed(imm)));
    m_start = s;
    m_done  = tout ? s + WAIT_MAX + 1 : s + 2 + nr;
    m_active = 1'b1;
    br_valid = 1'b1;
    br_op    = op;
    br_pc    = pc;
    br_imm   = imm;
    drive_ops(op, rs, rt, 1'b0);
    for (int c = s + 1; c <= m_done; c++) begin
      @(posedge clk); #1;
      if (c < m_done) drive_ops(op, rs, rt, (c - s - 1) >= nr);
      else begin
        br_valid = 1'b0;
        rs_ready = 1'b0;
        rt_ready = 1'b0;
      end
      if (drop && c == s + 2) br_valid = 1'b0;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; br_valid = 1'b0; br_op = 3'd0; br_pc = 32'd0; br_imm = 16'd0;
    rs_data = 32'd0; rt_data = 32'd0; rs_ready = 1'b0; rt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_br_cnt", 32'(br_cnt), 32'd0);
    chk("reset_pc", redirect_pc, 32'd0);

    // Operands ready immediately
    issue(3'd0, 32'h3000, 16'h0003, 32'h5, 32'h5, 0, 0);
    chk("t1_latency", 32'(cyc - g_start), 32'd2);
    chk("t1_redirect", {31'd0, redirect}, 32'd1);
    chk("t1_pc", redirect_pc, 32'h3010);
    chk("t1_br_cnt", 32'(br_cnt), 32'd1);
    chk("t1_taken_cnt", 32'(taken_cnt), 32'd1);

    // Delayed operand, br_valid dropped mid-WAIT
    issue(3'd2, 32'h4000, 16'h0010, 32'h1, 32'h0, 3, 1);
    chk("t2a_latency", 32'(cyc - g_start), 32'd5);
    chk("t2a_redirect", {31'd0, redirect}, 32'd1);
    chk("t2a_pc", redirect_pc, 32'h4044);
    issue(3'd2, 32'h4100, 16'h0010, 32'h8000_0000, 32'h0, 3, 0);
    chk("t2b_latency", 32'(cyc - g_start), 32'd5);
    chk("t2b_redirect", {31'd0, redirect}, 32'd0);
    chk("t2b_done", {31'd0, br_done}, 32'd1);
    chk("t2b_pc_held", redirect_pc, 32'h4044);

    // Timeout and the last-chance boundary
    issue(3'd1, 32'h5000, 16'h0004, 32'h1, 32'h2, WAIT_MAX, 0);
    chk("t3_latency", 32'(cyc - g_start), 32'd9);
    chk("t3_err", {31'd0, err}, 32'd1);
    chk("t3_redirect", {31'd0, redirect}, 32'd0);
    chk("t3_taken_cnt", 32'(taken_cnt), 32'd2);
    issue(3'd1, 32'h5100, 16'h0004, 32'h1, 32'h2, WAIT_MAX - 1, 0);
    chk("t3b_latency", 32'(cyc - g_start), 32'd9);
    chk("t3b_err", {31'd0, err}, 32'd0);
    chk("t3b_pc", redirect_pc, 32'h5114);

    // Illegal ops, negative offset, wrap, remaining conditions
    issue(3'd7, 32'h6000, 16'h0001, 32'h0, 32'h0, 0, 0);
    chk("t4_err7", {31'd0, err}, 32'd1);
    chk("t4_red7", {31'd0, redirect}, 32'd0);
    issue(3'd6, 32'h6000, 16'h0001, 32'h0, 32'h0, 1, 0);
    issue(3'd4, 32'h3000, 16'hFFFF, 32'h0, 32'h0, 0, 0);
    chk("t4_neg_pc", redirect_pc, 32'h3000);
    issue(3'd2, 32'hFFFF_FFF0, 16'h0004, 32'h7FFF_FFFF, 32'h0, 0, 0);
    chk("t4_wrap_pc", redirect_pc, 32'h0000_0004);
    issue(3'd3, 32'h7000, 16'h0008, 32'hFFFF_FFFF, 32'h0, 2, 0);
    issue(3'd0, 32'h7100, 16'h0008, 32'h1, 32'h2, 1, 0);
    issue(3'd5, 32'h7200, 16'h0008, 32'h8000_0000, 32'h0, 0, 0);
    issue(3'd4, 32'h7300, 16'h0008, 32'h1, 32'h0, 0, 0);
    issue(3'd3, 32'h7400, 16'h0008, 32'h0, 32'h0, 0, 0);
    issue(3'd2, 32'h7500, 16'h0008, 32'h0, 32'h0, 0, 0);
    issue(3'd1, 32'h7600, 16'h0008, 32'h9, 32'h9, 0, 0);

    // Reset while in WAIT
    @(posedge clk); #1;
    m_start = cyc; m_done = cyc + 1000; m_take = 1'b0; m_err = 1'b0; m_active = 1'b1;
    br_valid = 1'b1; br_op = 3'd0; br_pc = 32'h8000; br_imm = 16'h0001;
    drive_ops(3'd0, 32'h7, 32'h7, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("t5_pre_stall", {31'd0, stall}, 32'd1);
    #1 reset = 1'b1; br_valid = 1'b0;
    #1;
    chk("t5_stall", {31'd0, stall}, 32'd0);
    chk("t5_done", {31'd0, br_done}, 32'd0);
    chk("t5_redirect", {31'd0, redirect}, 32'd0);
    chk("t5_br_cnt", 32'(br_cnt), 32'd0);
    chk("t5_taken_cnt", 32'(taken_cnt), 32'd0);
    m_active = 1'b0; m_br = 0; m_tk = 0; m_last_pc = 32'd0;
    drive_ops(3'd0, 32'h7, 32'h7, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("t5_no_redirect", 32'(taken_cnt), 32'd0);

    // Saturation, back-to-back
    for (int i = 0; i < 5; i++) begin
      issue(3'd5, 32'h9000 + 32'(i * 16), 16'(i), 32'h0, 32'h0, 0, 0);
      chk("t6_latency", 32'(cyc - g_start), 32'd2);
      chk("t6_br_cnt", 32'(br_cnt), 32'((i + 1 < 3) ? i + 1 : 3));
      chk("t6_taken_cnt", 32'(taken_cnt), 32'((i + 1 < 3) ? i + 1 : 3));
    end

    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
